// File: rtl/bound_flasher_prog.sv
// Programmable bound flasher: walks a thermometer LED bar through a loadable
// table of bound targets, with step-rate divider, loop mode and kick-back.
module bound_flasher_prog #(
    parameter int N_LED   = 16,
    parameter int SEG_MAX = 8,
    parameter int DIV_W   = 8,
    parameter int CNT_W   = $clog2(N_LED + 1),
    parameter int SEG_W   = $clog2(SEG_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    input  logic             cfg_we,
    input  logic [SEG_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0] cfg_bound,
    input  logic             cfg_nseg_we,
    input  logic [SEG_W:0]   cfg_nseg,
    input  logic             cfg_loop,
    input  logic [DIV_W-1:0] tick_div,
    output logic [N_LED-1:0] LED,
    output logic             busy,
    output logic [SEG_W-1:0] seg_idx,
    output logic             done
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LED_MAX  = CNT_W'(N_LED);
    localparam logic [SEG_W:0]   NSEG_MAX = (SEG_W + 1)'(SEG_MAX);
    localparam logic [SEG_W:0]   NSEG_RST = (SEG_W + 1)'((SEG_MAX < 6) ? SEG_MAX : 6);

    // Power-up bound table, clamped to the bar length.
    function automatic logic [CNT_W-1:0] def_bound(input int idx);
        int v;
        case (idx)
            0:       v = 16;
            1:       v = 5;
            2:       v = 11;
            4:       v = 6;
            default: v = 0;
        endcase
        if (v > N_LED) begin
            v = N_LED;
        end
        return CNT_W'(v);
    endfunction

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   level_r, level_s;
    logic [SEG_W-1:0]   seg_s;
    logic [DIV_W-1:0]   div_r, div_s;
    logic               done_s;
    logic               flick_r;
    logic [CNT_W-1:0]   bound_tbl_r [SEG_MAX];
    logic [SEG_W:0]     nseg_r;
    logic               loop_r;

    logic               rise_s, step_s, kick_s, at_target_s, is_last_s, is_down_s;
    logic [CNT_W-1:0]   target_s, prev_s;
    logic [SEG_W-1:0]   prev_idx_s;

    assign rise_s      = flick & ~flick_r;
    assign prev_idx_s  = seg_idx - SEG_W'(1);
    assign target_s    = bound_tbl_r[seg_idx];
    assign prev_s      = bound_tbl_r[prev_idx_s];
    assign at_target_s = (level_r == target_s);
    assign is_down_s   = (seg_idx != '0) && (target_s < prev_s);
    assign is_last_s   = ({1'b0, seg_idx} == (nseg_r - (SEG_W + 1)'(1)));
    assign step_s      = (div_r == tick_div);
    assign kick_s      = (state_r == RUN) && rise_s && is_down_s && !is_last_s && at_target_s;
    assign busy        = (state_r == RUN);

    // Next-state: kick-back outranks the divider step; targets reached cost one step.
    always_comb begin
        state_s = state_r;
        level_s = level_r;
        seg_s   = seg_idx;
        div_s   = div_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                level_s = '0;
                seg_s   = '0;
                div_s   = '0;
                if (rise_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                div_s = step_s ? '0 : div_r + DIV_W'(1);
                if (kick_s) begin
                    seg_s   = prev_idx_s;
                    level_s = (level_r == LED_MAX) ? level_r : level_r + CNT_W'(1);
                    div_s   = '0;
                end else if (step_s) begin
                    if (level_r < target_s) begin
                        level_s = level_r + CNT_W'(1);
                    end else if (level_r > target_s) begin
                        level_s = level_r - CNT_W'(1);
                    end else if (!is_last_s) begin
                        seg_s = seg_idx + SEG_W'(1);
                    end else if (loop_r) begin
                        seg_s = '0;
                    end else begin
                        state_s = IDLE;
                        level_s = '0;
                        seg_s   = '0;
                        done_s  = 1'b1;
                    end
                end else begin
                    level_s = level_r;
                end
            end
            default: begin
                state_s = IDLE;
                level_s = '0;
                seg_s   = '0;
                div_s   = '0;
            end
        endcase
    end

    // Run state, level, segment, divider and button history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            level_r <= '0;
            seg_idx <= '0;
            div_r   <= '0;
            done    <= 1'b0;
            flick_r <= 1'b0;
        end else begin
            state_r <= state_s;
            level_r <= level_s;
            seg_idx <= seg_s;
            div_r   <= div_s;
            done    <= done_s;
            flick_r <= flick;
        end
    end

    // Configuration: only writable while idle, values clamped on the way in.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEG_MAX; i++) begin
                bound_tbl_r[i] <= def_bound(i);
            end
            nseg_r <= NSEG_RST;
            loop_r <= 1'b0;
        end else if (state_r == IDLE) begin
            for (int i = 0; i < SEG_MAX; i++) begin
                if (cfg_we && (cfg_addr == SEG_W'(i))) begin
                    bound_tbl_r[i] <= (cfg_bound > LED_MAX) ? LED_MAX : cfg_bound;
                end
            end
            if (cfg_nseg_we) begin
                if (cfg_nseg == '0) begin
                    nseg_r <= (SEG_W + 1)'(1);
                end else if (cfg_nseg > NSEG_MAX) begin
                    nseg_r <= NSEG_MAX;
                end else begin
                    nseg_r <= cfg_nseg;
                end
                loop_r <= cfg_loop;
            end
        end
    end

    // Thermometer decode of the registered level.
    always_comb begin
        LED = '0;
        for (int i = 0; i < N_LED; i++) begin
            LED[i] = (level_r > CNT_W'(i));
        end
    end

endmodule

// File: tb/tb_bound_flasher_prog.sv
// Scoreboard bench for bound_flasher_prog: expected per-cycle observations are
// generated from the bound table and compared sample by sample.
module tb_bound_flasher_prog;

    logic        clk = 1'b0;
    logic        rst, flick, cfg_we, cfg_nseg_we, cfg_loop;
    logic [2:0]  cfg_addr;
    logic [4:0]  cfg_bound;
    logic [3:0]  cfg_nseg;
    logic [7:0]  tick_div;
    logic [15:0] LED;
    logic        busy, done;
    logic [2:0]  seg_idx;

    typedef struct packed {
        logic [15:0] led;
        logic        busy;
        logic [2:0]  seg;
        logic        done;
    } obs_t;

    obs_t got, exp_o;
    obs_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   exp_tab[8];
    int   exp_nseg;
    bit   exp_loop;

    assign got = {LED, busy, seg_idx, done};

    always #5 clk = ~clk;

    bound_flasher_prog dut (
        .clk(clk), .rst(rst), .flick(flick),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bound(cfg_bound),
        .cfg_nseg_we(cfg_nseg_we), .cfg_nseg(cfg_nseg), .cfg_loop(cfg_loop),
        .tick_div(tick_div), .LED(LED), .busy(busy), .seg_idx(seg_idx), .done(done)
    );

    function automatic obs_t mk(input int lvl, input int seg, input bit b, input bit d);
        logic [16:0] t;
        obs_t o;
        t = (17'h1 << lvl) - 17'h1;
        o.led = t[15:0];
        o.busy = b;
        o.seg = seg[2:0];
        o.done = d;
        return o;
    endfunction

    // Walk each segment toward its bound; every move or boundary waits tick extra samples.
    task automatic gen(input int tick, input int max_samp);
        int lvl = 0;
        int seg = 0;
        int n = 1;
        q.delete();
        q.push_back(mk(0, 0, 1'b1, 1'b0));
        while (n < max_samp) begin
            repeat (tick) q.push_back(mk(lvl, seg, 1'b1, 1'b0));
            n += tick;
            if (lvl < exp_tab[seg]) lvl++;
            else if (lvl > exp_tab[seg]) lvl--;
            else if (seg + 1 < exp_nseg) seg++;
            else if (exp_loop) seg = 0;
            else begin
                q.push_back(mk(0, 0, 1'b0, 1'b1));
                q.push_back(mk(0, 0, 1'b0, 1'b0));
                break;
            end
            q.push_back(mk(lvl, seg, 1'b1, 1'b0));
            n++;
        end
    endtask

    task automatic set_default_table();
        exp_tab = '{16, 5, 11, 0, 6, 0, 0, 0};
        exp_nseg = 6;
        exp_loop = 1'b0;
    endtask

    task automatic report(input string name, input obs_t a, input obs_t e);
        $display("FAIL %s: got LED=%h busy=%b seg=%0d done=%b, want LED=%h busy=%b seg=%0d done=%b",
                 name, a.led, a.busy, a.seg, a.done, e.led, e.busy, e.seg, e.done);
    endtask

    task automatic run_check(input string name, input int wr_at);
        int i = 0;
        @(negedge clk) flick = 1'b1;
        while (q.size() > 0) begin
            @(negedge clk);
            flick = 1'b0;
            cfg_we = 1'b0;
            cfg_nseg_we = 1'b0;
            if (i == wr_at) begin
                cfg_we = 1'b1; cfg_addr = 3'd0; cfg_bound = 5'd9;
                cfg_nseg_we = 1'b1; cfg_nseg = 4'd1; cfg_loop = 1'b0;
            end
            exp_o = q.pop_front();
            compared++;
            if (got !== exp_o) begin
                mismatched++;
                report($sformatf("%s[%0d]", name, i), got, exp_o);
            end
            i++;
        end
        cfg_we = 1'b0;
        cfg_nseg_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_for(input int seg, input logic [15:0] led, input int budget, input string name);
        bit found = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            flick = 1'b0;
            if (seg_idx == seg[2:0] && LED == led) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL %s: timeout, got LED=%h seg=%0d, want LED=%h seg=%0d", name, LED, seg_idx, led, seg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (got !== mk(0, 0, 1'b0, 1'b0)) begin mismatched++; report("reset", got, mk(0, 0, 1'b0, 1'b0)); end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (got !== mk(0, 0, 1'b0, 1'b0)) begin mismatched++; report("post_reset", got, mk(0, 0, 1'b0, 1'b0)); end
    endtask

    task automatic test_default_run();
        set_default_table();
        tick_div = 8'd0;
        gen(0, 1000);
        run_check("default_run", -1);
    endtask

    task automatic test_divider();
        set_default_table();
        tick_div = 8'd3;
        gen(3, 1000);
        run_check("divider", -1);
        tick_div = 8'd0;
    endtask

    task automatic test_kickback();
        tick_div = 8'd7;
        @(negedge clk) flick = 1'b1;
        wait_for(1, 16'h007F, 600, "kick_wait_l7");
        flick = 1'b1;
        @(negedge clk) flick = 1'b0;
        compared++;
        if (got !== mk(7, 1, 1'b1, 1'b0)) begin mismatched++; report("kick_ignored_l7", got, mk(7, 1, 1'b1, 1'b0)); end
        wait_for(1, 16'h001F, 100, "kick_wait_l5");
        flick = 1'b1;
        @(negedge clk) flick = 1'b0;
        compared++;
        if (got !== mk(6, 0, 1'b1, 1'b0)) begin mismatched++; report("kick_back", got, mk(6, 0, 1'b1, 1'b0)); end
        repeat (7) begin
            @(negedge clk);
            compared++;
            if (got !== mk(6, 0, 1'b1, 1'b0)) begin mismatched++; report("kick_div_restart", got, mk(6, 0, 1'b1, 1'b0)); end
        end
        @(negedge clk);
        compared++;
        if (got !== mk(7, 0, 1'b1, 1'b0)) begin mismatched++; report("kick_climb", got, mk(7, 0, 1'b1, 1'b0)); end
        wait_for(0, 16'hFFFF, 200, "kick_reach_top");
        do_reset();
        tick_div = 8'd0;
    endtask

    task automatic test_programming();
        @(negedge clk);
        cfg_nseg_we = 1'b1; cfg_nseg = 4'd2; cfg_loop = 1'b1;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_bound = 5'd4;
        @(negedge clk);
        cfg_nseg_we = 1'b0;
        cfg_addr = 3'd1; cfg_bound = 5'd2;
        @(negedge clk);
        cfg_we = 1'b0;
        exp_tab = '{4, 2, 0, 0, 0, 0, 0, 0};
        exp_nseg = 2;
        exp_loop = 1'b1;
        gen(0, 40);
        run_check("program_loop", 10);
        do_reset();
    endtask

    task automatic test_clamping();
        @(negedge clk);
        cfg_nseg_we = 1'b1; cfg_nseg = 4'd0; cfg_loop = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_bound = 5'd31;
        @(negedge clk);
        cfg_we = 1'b0; cfg_nseg_we = 1'b0;
        exp_tab = '{16, 0, 0, 0, 0, 0, 0, 0};
        exp_nseg = 1;
        exp_loop = 1'b0;
        gen(0, 1000);
        run_check("clamping", -1);
    endtask

    task automatic test_reset_midrun();
        tick_div = 8'd0;
        @(negedge clk) flick = 1'b1;
        wait_for(0, 16'h01FF, 50, "midrun_wait_l9");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (got !== mk(0, 0, 1'b0, 1'b0)) begin mismatched++; report("reset_midrun", got, mk(0, 0, 1'b0, 1'b0)); end
        set_default_table();
        gen(0, 1000);
        run_check("table_after_reset", -1);
    endtask

    initial begin
        rst = 1'b1; flick = 1'b0; cfg_we = 1'b0; cfg_nseg_we = 1'b0; cfg_loop = 1'b0;
        cfg_addr = 3'd0; cfg_bound = 5'd0; cfg_nseg = 4'd0; tick_div = 8'd0;
        test_reset();
        test_default_run();
        test_divider();
        test_kickback();
        test_programming();
        test_clamping();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bound_flasher_prog.md
Name: bound_flasher_prog

Overview:
Programmable successor to the fixed 16-LED bound flasher. It drives an N_LED-wide thermometer bar up and down through a run-time-loadable sequence of up to SEG_MAX bound targets. A flick input starts a run and can also kick back one segment. Also adds a step-rate divider, a loop mode and a done pulse. It sits between the board's push-button conditioning and the LED bank.

Parameters:
N_LED, 16, number of LEDs in the bar (2..64)
SEG_MAX, 8, depth of the bound table (2..16)
DIV_W, 8, width of the step-rate divider
CNT_W, $clog2(N_LED+1), derived width of level and bound values; not to be overridden
SEG_W, $clog2(SEG_MAX), derived width of the segment index; not to be overridden

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
flick  in  1  level input from the button, already debounced; the block acts on rising edges
cfg_we  in  1  table/control write strobe; accepted only while busy=0
cfg_addr  in  SEG_W  bound table entry to write
cfg_bound  in  CNT_W  bound value; clamped to N_LED on write
cfg_nseg_we  in  1  write strobe for segment count and loop; accepted only while busy=0
cfg_nseg  in  SEG_W+1  number of active segments; clamped to 1..SEG_MAX
cfg_loop  in  1  1 = restart at segment 0 after the last segment instead of going to IDLE
tick_div  in  DIV_W  step period minus 1, in clk cycles (0 = one step per cycle); sampled live
LED  out  N_LED  thermometer output: LED[i] = (i < level)
busy  out  1  1 while in RUN
seg_idx  out  SEG_W  current segment index
done  out  1  one-cycle pulse when a non-loop run completes

Behaviour:
- Flick edge detection: flick_q register; rise = flick & ~flick_q. rst clears flick_q to 0.
- Reset values:
  - state=IDLE, level=0, seg_idx=0, div counter=0, done=0, busy=0, LED=0.
  - nseg=6, loop=0.
  - Table = {16,5,11,0,6,0}, each entry min(value, N_LED); entries 6 and above = 0.
  - Reset mid-run aborts the run immediately. Next cycle shows LED=0.
- States: IDLE, RUN.
  - IDLE: level=0, seg_idx=0. On rise: go to RUN, div counter=0, level unchanged (0).
  - RUN: div counter increments each cycle. step = (counter==tick_div); counter returns to 0 on step. If tick_div is lowered below counter, the counter wraps at 2^DIV_W.
- RUN step rules, with target = table[seg_idx]:
  - level < target: level+1.
  - level > target: level-1.
  - level == target, and seg_idx < nseg-1: seg_idx+1, level unchanged. A segment boundary costs exactly one step.
  - level == target, and seg_idx == nseg-1, loop=1: seg_idx=0, level unchanged.
  - level == target, and seg_idx == nseg-1, loop=0: go to IDLE, level=0, seg_idx=0, done=1 for 1 cycle.
- Direction is implicit. A segment is DOWN when target < table[seg_idx-1]. Segment 0 is always UP.
- Kick-back, evaluated every cycle, not gated by step:
  - Condition: rise while RUN, AND segment is DOWN, AND seg_idx != nseg-1, AND level == target.
  - Effect: seg_idx-1, level+1 (saturating at N_LED), div counter=0.
  - Kick-back has priority over a coincident step.
- rise in RUN without the kick-back condition is ignored. A run is never restarted from RUN.
- Config writes while busy=1 are dropped; table contents do not change mid-run.
- cfg_we and cfg_nseg_we in the same cycle both take effect.
- LED is a pure decode of the registered level; no added latency. busy = (state==RUN).
- rise in the same cycle as the IDLE-entering step stays in IDLE; the flick must be re-pressed.

Test Plan:
- Defaults, N_LED=16, tick_div=0: rst 2 cycles, flick 0→1 → LED climbs 0x0001..0xFFFF, falls to 0x001F, rises to 0x07FF, falls to 0, rises to 0x003F, falls to 0. Then done pulses once, busy=0, LED=0. Total RUN length = 16+11+6+11+6+6 level steps + 6 boundary steps.
- Kick-back: defaults; in segment 1 hold level=5 (LED=0x001F), pulse flick → next cycle seg_idx=0, LED=0x003F, climbs again to 0xFFFF. Flick at level=7 in segment 1 → no effect.
- Divider: tick_div=3 → level changes exactly every 4 cycles. Flick rise in IDLE → first LED change 4 cycles after entering RUN.
- Programming: while IDLE write nseg=2, table={4,2}, loop=1 → LED pattern 0x0,0x1,0x3,0x7,0xF,(hold),0x7,0x3,(hold),0x7,0xF... repeating, never done. A cfg_we during the run leaves the pattern unchanged.
- Clamping: N_LED=8; write cfg_bound=15 to entry 0 → level peaks at 8 (LED=0xFF). Write cfg_nseg=0 → behaves as nseg=1.
- Reset mid-run: assert rst at level=9 → next cycle LED=0, busy=0, seg_idx=0. Table returns to defaults.
